// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encoding and the default word width.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready on both sides.
// Back-to-back words are accepted on the last-bit transfer with no gap cycle.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             frame_last,
    output logic             busy
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_acc;
    logic             xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        load_acc  = load_valid && load_ready;
        xfer      = serial_valid && serial_ready;
        case (state)
            IDLE: begin
                if (load_acc) begin
                    shreg_nxt = parallel_in;
                    cnt_nxt   = CNT_TOP;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A load in SHIFT can only happen together with the last-bit transfer
                if (xfer) begin
                    if (load_acc) begin
                        shreg_nxt = parallel_in;
                        cnt_nxt   = CNT_TOP;
                    end else if (cnt == '0) begin
                        shreg_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                              : {1'b0, shreg[WIDTH-1:1]};
                        cnt_nxt   = cnt - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == SHIFT);
        serial_valid = busy;
        frame_last   = busy && (cnt == '0);
        serial_out   = busy ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
        load_ready   = (state == IDLE) ? 1'b1 : ((cnt == '0) && serial_ready);
    end

endmodule
